// File: rtl/hasti_pkg.sv
// Shared AHB-Lite definitions for the two-master arbiter: transfer encodings,
// bus widths, the address-phase request bundle and master identifiers.
package hasti_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] haddr;
        logic              hwrite;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic [1:0]        htrans;
        logic              hmastlock;
    } hasti_req_t;

    typedef enum logic {
        MASTER_0 = 1'b0,
        MASTER_1 = 1'b1
    } master_e;

    function automatic logic req_active(input hasti_req_t r);
        return r.htrans != HTRANS_IDLE;
    endfunction

    // An owner mid-burst or holding a lock keeps the bus.
    function automatic logic req_holds_bus(input hasti_req_t r);
        return (r.htrans == HTRANS_SEQ) || (r.htrans == HTRANS_BUSY) || r.hmastlock;
    endfunction

endpackage

// File: rtl/hasti_skid_buffer.sv
// Single-entry holding register for an address phase that was accepted from a
// master but could not be issued to the slave in the same cycle.
module hasti_skid_buffer
    import hasti_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_capture,
    input  logic       i_clear,
    input  hasti_req_t i_req,
    output logic       o_valid,
    output hasti_req_t o_req
);

    logic       r_valid;
    hasti_req_t r_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    // Payload is only meaningful while r_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (i_capture) begin
            r_req <= i_req;
        end
    end

    assign o_valid = r_valid;
    assign o_req   = r_req;

endmodule

// File: rtl/hasti_arbiter.sv
// Two-master round-robin AHB-Lite arbiter onto one slave port, with a skid
// buffer per master so that losing an arbitration never drops a transfer.
module hasti_arbiter
    import hasti_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] io_masters_0_haddr,
    input  logic              io_masters_0_hwrite,
    input  logic [2:0]        io_masters_0_hsize,
    input  logic [2:0]        io_masters_0_hburst,
    input  logic [3:0]        io_masters_0_hprot,
    input  logic [1:0]        io_masters_0_htrans,
    input  logic              io_masters_0_hmastlock,
    input  logic [DATA_W-1:0] io_masters_0_hwdata,
    output logic [DATA_W-1:0] io_masters_0_hrdata,
    output logic              io_masters_0_hready,
    output logic              io_masters_0_hresp,

    input  logic [ADDR_W-1:0] io_masters_1_haddr,
    input  logic              io_masters_1_hwrite,
    input  logic [2:0]        io_masters_1_hsize,
    input  logic [2:0]        io_masters_1_hburst,
    input  logic [3:0]        io_masters_1_hprot,
    input  logic [1:0]        io_masters_1_htrans,
    input  logic              io_masters_1_hmastlock,
    input  logic [DATA_W-1:0] io_masters_1_hwdata,
    output logic [DATA_W-1:0] io_masters_1_hrdata,
    output logic              io_masters_1_hready,
    output logic              io_masters_1_hresp,

    output logic [ADDR_W-1:0] io_slave_haddr,
    output logic              io_slave_hwrite,
    output logic [2:0]        io_slave_hsize,
    output logic [2:0]        io_slave_hburst,
    output logic [3:0]        io_slave_hprot,
    output logic [1:0]        io_slave_htrans,
    output logic              io_slave_hmastlock,
    output logic [DATA_W-1:0] io_slave_hwdata,
    input  logic [DATA_W-1:0] io_slave_hrdata,
    input  logic              io_slave_hready,
    input  logic              io_slave_hresp
);

    hasti_req_t w_live [2];
    hasti_req_t w_buf  [2];
    hasti_req_t w_eff  [2];
    hasti_req_t w_sel;
    logic [1:0] w_buf_valid;
    logic [1:0] w_active;
    logic [1:0] w_capture;
    logic [1:0] w_clear;
    logic [1:0] w_own;
    logic [1:0] w_mst_hready;
    logic       w_issue;

    master_e    r_grant;
    master_e    w_grant;
    master_e    r_last_grant;
    master_e    r_dphase_owner;
    logic       r_dphase_valid;

    assign w_live[0] = '{haddr: io_masters_0_haddr, hwrite: io_masters_0_hwrite,
                         hsize: io_masters_0_hsize, hburst: io_masters_0_hburst,
                         hprot: io_masters_0_hprot, htrans: io_masters_0_htrans,
                         hmastlock: io_masters_0_hmastlock};
    assign w_live[1] = '{haddr: io_masters_1_haddr, hwrite: io_masters_1_hwrite,
                         hsize: io_masters_1_hsize, hburst: io_masters_1_hburst,
                         hprot: io_masters_1_hprot, htrans: io_masters_1_htrans,
                         hmastlock: io_masters_1_hmastlock};

    hasti_skid_buffer u_buf0 (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_capture[0]),
        .i_clear   (w_clear[0]),
        .i_req     (w_live[0]),
        .o_valid   (w_buf_valid[0]),
        .o_req     (w_buf[0])
    );

    hasti_skid_buffer u_buf1 (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_capture[1]),
        .i_clear   (w_clear[1]),
        .i_req     (w_live[1]),
        .o_valid   (w_buf_valid[1]),
        .o_req     (w_buf[1])
    );

    always_comb begin
        w_eff[0]    = w_buf_valid[0] ? w_buf[0] : w_live[0];
        w_eff[1]    = w_buf_valid[1] ? w_buf[1] : w_live[1];
        w_active[0] = req_active(w_eff[0]);
        w_active[1] = req_active(w_eff[1]);
    end

    // Next-grant logic; grant is frozen while the slave stalls.
    always_comb begin
        w_grant = r_grant;
        if (io_slave_hready && !req_holds_bus(w_eff[r_grant])) begin
            if (w_active[0] && w_active[1]) begin
                w_grant = (r_last_grant == MASTER_0) ? MASTER_1 : MASTER_0;
            end else if (w_active[0]) begin
                w_grant = MASTER_0;
            end else if (w_active[1]) begin
                w_grant = MASTER_1;
            end
        end
    end

    assign w_issue = io_slave_hready && w_active[w_grant];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant        <= MASTER_0;
            r_last_grant   <= MASTER_1;
            r_dphase_valid <= 1'b0;
            r_dphase_owner <= MASTER_0;
        end else begin
            r_grant <= w_grant;
            if (io_slave_hready) begin
                r_dphase_valid <= w_issue;
                if (w_issue) begin
                    r_dphase_owner <= w_grant;
                    if (w_eff[w_grant].htrans == HTRANS_NONSEQ) begin
                        r_last_grant <= w_grant;
                    end
                end
            end
        end
    end

    always_comb begin
        w_sel              = w_eff[w_grant];
        io_slave_haddr     = w_sel.haddr;
        io_slave_hwrite    = w_sel.hwrite;
        io_slave_hsize     = w_sel.hsize;
        io_slave_hburst    = w_sel.hburst;
        io_slave_hprot     = w_sel.hprot;
        io_slave_hmastlock = w_sel.hmastlock;
        io_slave_htrans    = w_active[w_grant] ? w_sel.htrans : HTRANS_IDLE;
    end

    assign w_own[0] = r_dphase_valid && (r_dphase_owner == MASTER_0);
    assign w_own[1] = r_dphase_valid && (r_dphase_owner == MASTER_1);

    assign w_mst_hready[0] = w_own[0] ? io_slave_hready : ~w_buf_valid[0];
    assign w_mst_hready[1] = w_own[1] ? io_slave_hready : ~w_buf_valid[1];

    // A master seeing hready=1 considers its address phase taken, so anything
    // live that does not issue this cycle (lost arbitration or slave stall) is held.
    assign w_capture[0] = req_active(w_live[0]) && w_mst_hready[0] && !w_buf_valid[0]
                          && !(w_issue && (w_grant == MASTER_0));
    assign w_capture[1] = req_active(w_live[1]) && w_mst_hready[1] && !w_buf_valid[1]
                          && !(w_issue && (w_grant == MASTER_1));
    assign w_clear[0]   = w_issue && (w_grant == MASTER_0);
    assign w_clear[1]   = w_issue && (w_grant == MASTER_1);

    assign io_slave_hwdata     = (r_dphase_owner == MASTER_1) ? io_masters_1_hwdata
                                                              : io_masters_0_hwdata;
    assign io_masters_0_hrdata = io_slave_hrdata;
    assign io_masters_1_hrdata = io_slave_hrdata;
    assign io_masters_0_hready = w_mst_hready[0];
    assign io_masters_1_hready = w_mst_hready[1];
    assign io_masters_0_hresp  = w_own[0] ? io_slave_hresp : 1'b0;
    assign io_masters_1_hresp  = w_own[1] ? io_slave_hresp : 1'b0;

endmodule
